serial_add_controller: RTL and testbench

Sequencer that drives an external bit-serial adder (one-bit full adder plus carry flip-flop) to produce a full WIDTH-bit addition. It latches two parallel operands on `start` and clears the adder's carry. It then streams operand bits LSB-first for WIDTH cycles and collects the serial sum bits into a parallel result with the final carry. It sits between a parallel requester and the serial adder datapath and owns the adder's `shift_control`, data inputs and carry clear.

---
 rtl/serial_add_controller.sv | 122 ++++++++++++
 tb/tb_serial_add_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_controller.sv
// Sequencer for an external bit-serial adder: latches two operands, clears the
// adder carry, streams bits LSB-first and gathers the serial sum into a parallel result.
module serial_add_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             sa_clear,
    output logic             sa_shift_control,
    output logic             sa_data_in1,
    output logic             sa_data_in2,
    input  logic             sa_sum,
    input  logic             sa_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             clear_st;

    always_comb begin
        state_d          = state_q;
        a_sr_d           = a_sr_q;
        b_sr_d           = b_sr_q;
        res_sr_d         = res_sr_q;
        cnt_d            = cnt_q;
        result_d         = result_q;
        carry_out_d      = carry_out_q;
        clear_st         = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        sa_shift_control = 1'b0;
        sa_data_in1      = 1'b0;
        sa_data_in2      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = op_a;
                    b_sr_d  = op_b;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy     = 1'b1;
                clear_st = 1'b1;
                cnt_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                busy             = 1'b1;
                sa_shift_control = 1'b1;
                sa_data_in1      = a_sr_q[0];
                sa_data_in2      = b_sr_q[0];
                a_sr_d           = a_sr_q >> 1;
                b_sr_d           = b_sr_q >> 1;
                res_sr_d         = {sa_sum, res_sr_q[WIDTH-1:1]};
                cnt_d            = cnt_q + CW'(1);
                // The final sum bit is still on sa_sum this cycle, so publish the shifted value.
                if (cnt_q == LAST_BIT) begin
                    result_d    = {sa_sum, res_sr_q[WIDTH-1:1]};
                    carry_out_d = sa_cout;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset also clears the adder's carry flop through the same line.
    assign sa_clear  = ~reset | clear_st;
    assign result    = result_q;
    assign carry_out = carry_out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_sr_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_sr_q    <= res_sr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

endmodule

// File: tb/tb_serial_add_controller.sv
// Bench for serial_add_controller with a behavioural serial adder attached; stimulus
// pushes expected {carry, sum} and done cycle, a monitor pops on each done pulse.
module tb_serial_add_controller;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, carry_out;
    logic [W-1:0] result;
    logic         sa_clear, sa_shift_control, sa_data_in1, sa_data_in2;
    logic         sa_sum, sa_cout;
    logic         adder_carry_q;

    serial_add_controller #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .sa_clear(sa_clear), .sa_shift_control(sa_shift_control),
        .sa_data_in1(sa_data_in1), .sa_data_in2(sa_data_in2),
        .sa_sum(sa_sum), .sa_cout(sa_cout)
    );

    always #5 clk = ~clk;

    // External one-bit full adder with carry flop; clear has priority.
    always @(posedge clk) begin
        if (sa_clear) adder_carry_q <= 1'b0;
        else if (sa_shift_control) adder_carry_q <= sa_cout;
    end
    assign sa_sum  = sa_data_in1 ^ sa_data_in2 ^ adder_carry_q;
    assign sa_cout = (sa_data_in1 & sa_data_in2) | (sa_data_in1 & adder_carry_q) |
                     (sa_data_in2 & adder_carry_q);

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [W:0]  exp_q[$];
    int          cyc_q[$];
    int          last_e = 0;
    logic        mon_en = 1'b0;
    logic        abort = 1'b0;
    int          busy_cnt = 0, shift_cnt = 0, clear_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples after the driver has settled on each falling edge.
    always @(negedge clk) begin
        logic [W:0] e;
        int         ec;
        #2;
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (sa_shift_control) shift_cnt++;
            if (sa_clear && reset) clear_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("sum_carry", 32'({carry_out, result}), 32'(e));
                    check("done_latency", 32'(cyc), 32'(ec));
                    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
                    check("shift_cycles", 32'(shift_cnt), 32'(W));
                    check("clear_cycles", 32'(clear_cnt), 32'd1);
                end
                busy_cnt  = 0;
                shift_cnt = 0;
                clear_cnt = 0;
            end
            if (abort) begin
                busy_cnt  = 0;
                shift_cnt = 0;
                clear_cnt = 0;
                abort     = 1'b0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp);
        int guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("idle_timeout", 32'(busy), 32'd0);
            return;
        end
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + W + 2);
        last_e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
    endtask

    initial begin
        int guard;
        logic [W-1:0] ra, rb;
        reset = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, sa_shift_control, sa_data_in1, sa_data_in2,
                                    carry_out, result}), 32'd0);
        check("reset_sa_clear", 32'(sa_clear), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("idle_sa_clear", 32'(sa_clear), 32'd0);
        mon_en = 1'b1;

        issue(8'h5A, 8'h3C, 9'h096);
        issue(8'hFF, 8'h01, 9'h100);
        issue(8'hFF, 8'hFF, 9'h1FE);
        issue(8'h01, 8'h01, 9'h002);

        // Starts in cycle 3 (SHIFT) and cycle 10 (DONE) must be ignored.
        issue(8'h0F, 8'h01, 9'h010);
        while (cyc < last_e + 11) begin
            @(negedge clk);
            if (cyc == last_e + 2 || cyc == last_e + 9) begin
                start = 1'b1;
                op_a  = 8'h11;
                op_b  = 8'h22;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        #1;
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Abort with reset in cycle 5.
        issue(8'hAA, 8'h55, 9'h0FF);
        while (cyc < last_e + 4) @(negedge clk);
        reset = 1'b0;
        abort = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        #1;
        check("abort_sa_clear", 32'(sa_clear), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'({busy, done, sa_shift_control, sa_data_in1, sa_data_in2,
                                    sa_clear, carry_out, result}), 32'd0);
        repeat (15) @(negedge clk);
        issue(8'h80, 8'h80, 9'h100);
        issue(8'h00, 8'h00, 9'h000);

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = W'($urandom);
            rb = W'($urandom);
            issue(ra, rb, {1'b0, ra} + {1'b0, rb});
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
